uart_tx_mmio: RTL and testbench

- Memory-mapped UART transmitter on the data-memory bus; it sits downstream of the RAM/memory-map decoder.
- It consumes the decoder's `uart` select, `memwrite` and `memOut` (write data), and returns a status word on the decoder's `memIn` path.
- Written bytes are buffered in a small FIFO and serialised 8N1, LSB first, on a single TX pin.

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/uart_tx_mmio.sv | 158 +++++++++++++++
 tb/tb_uart_tx_mmio.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding, status-word bit positions and the control-write flag.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int STAT_OVF   = 15;
  localparam int STAT_FULL  = 14;
  localparam int STAT_EMPTY = 13;
  localparam int STAT_BUSY  = 12;

  localparam int CTRL_BIT   = 15;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a combinational head; a push arriving while full is accepted only if a pop happens in
// the same cycle, otherwise it is dropped and flagged for one cycle.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic                  full,
  output logic                  empty,
  output logic                  dropped,
  output logic [DEPTH_LOG2:0]   count
);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full     = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign dropped  = push & ~do_push;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: bus writes are queued in a FIFO and sent LSB first, frames back to back
// while data remains; a push accepted at edge N is popped at N+1; writes to a full FIFO are dropped and set a sticky overflow.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 16,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        sel,
  input  logic        write,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        tx,
  output logic        irq_empty
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

  logic                  bus_wr;
  logic                  ctrl_wr;
  logic                  push;
  logic                  pop;
  logic [7:0]            fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_dropped;
  logic [DEPTH_LOG2:0]   fifo_count;
  logic                  overflow;
  logic                  unused_bits;

  tx_state_t             state, state_n;
  logic [BAUD_W-1:0]     baud, baud_n;
  logic [2:0]            bit_idx, bit_idx_n;
  logic [7:0]            shift, shift_n;
  logic                  tx_n;

  assign bus_wr      = sel & write;
  assign ctrl_wr     = bus_wr & wr_data[CTRL_BIT];
  assign push        = bus_wr & ~wr_data[CTRL_BIT];
  assign unused_bits = ^wr_data[14:8];

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH      (FIFO_DEPTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (push),
    .push_data (wr_data[7:0]),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .dropped   (fifo_dropped),
    .count     (fifo_count)
  );

  always_ff @(posedge CLK) begin
    if (RST)               overflow <= 1'b0;
    else if (ctrl_wr)      overflow <= 1'b0;
    else if (fifo_dropped) overflow <= 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      tx      <= tx_n;
    end
  end

  always_comb begin
    state_n   = state;
    baud_n    = baud;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = fifo_head;
          baud_n  = BAUD_RELOAD;
          state_n = START;
        end
      end
      START: begin
        if (baud == '0) begin
          baud_n    = BAUD_RELOAD;
          bit_idx_n = 3'd0;
          state_n   = DATA;
        end else begin
          baud_n = baud - 1'b1;
        end
      end
      DATA: begin
        if (baud == '0) begin
          baud_n = BAUD_RELOAD;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            shift_n   = shift >> 1;
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          baud_n = baud - 1'b1;
        end
      end
      STOP: begin
        // Chain straight into the next start bit so queued bytes go out with no idle gap.
        if (baud == '0) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = fifo_head;
            baud_n  = BAUD_RELOAD;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  assign irq_empty = fifo_empty & (state == IDLE);

  always_comb begin
    rd_data                 = '0;
    rd_data[STAT_OVF]       = overflow;
    rd_data[STAT_FULL]      = fifo_full;
    rd_data[STAT_EMPTY]     = fifo_empty;
    rd_data[STAT_BUSY]      = (state != IDLE);
    rd_data[DEPTH_LOG2:0]   = fifo_count;
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: serial frames are decoded off tx and scored against bytes queued at write time.
module tb_uart_tx_mmio;

  localparam int CPB = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        sel = 1'b0;
  logic        write = 1'b0;
  logic [15:0] wr_data = 16'h0000;
  logic [15:0] rd_data;
  logic        tx;
  logic        irq_empty;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];

  bit         mon_act = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = 8'h00;

  typedef struct {
    logic        s;
    logic        w;
    logic [15:0] d;
    logic [15:0] exp_rd;
    logic        exp_irq;
    logic        acc;
  } vec_t;

  vec_t tbl[21];

  uart_tx_mmio #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (16),
    .DEPTH_LOG2   (4)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .sel       (sel),
    .write     (write),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .tx        (tx),
    .irq_empty (irq_empty)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic bus_op(input logic s, input logic w, input logic [15:0] d);
    sel     = s;
    write   = w;
    wr_data = d;
    @(posedge CLK);
    #1;
    sel     = 1'b0;
    write   = 1'b0;
    wr_data = 16'h0000;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_act || irq_empty !== 1'b1) && n < budget) begin
      idle(1);
      n++;
    end
    if (n >= budget) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d frames still pending after %0d cycles", exp_q.size(), budget);
    end
    idle(2);
  endtask

  // Serial monitor: sample tx mid-bit on the falling edge, LSB first.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST) begin
        mon_act = 1'b0;
      end else if (!mon_act) begin
        if (tx === 1'b0) begin
          mon_act  = 1'b1;
          mon_cnt  = 0;
          mon_byte = 8'h00;
          start_q.push_back(cyc);
        end
      end else begin
        mon_cnt++;
        if (mon_cnt == 2) check("start_bit", {31'd0, tx}, 32'd0);
        if (mon_cnt >= 6 && mon_cnt <= 34 && (mon_cnt % 4) == 2) mon_byte = {tx, mon_byte[7:1]};
        if (mon_cnt == 38) check("stop_bit", {31'd0, tx}, 32'd1);
        if (mon_cnt == 39) begin
          mon_act = 1'b0;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL frame_unexpected: got byte %0h expected no frame", mon_byte);
          end else begin
            check("frame_byte", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         e1;
    int         n0;
    logic [9:0] fr;

    for (int i = 0; i < 17; i++) begin
      tbl[i].s       = 1'b1;
      tbl[i].w       = 1'b1;
      tbl[i].d       = (i == 3) ? 16'h7F43 : 16'(16'h0040 + i);
      tbl[i].exp_rd  = (i == 0)  ? 16'h0001 :
                       (i == 16) ? 16'h5010 : 16'(16'h1000 + i);
      tbl[i].exp_irq = 1'b0;
      tbl[i].acc     = 1'b1;
    end
    tbl[17] = '{1'b0, 1'b1, 16'h0099, 16'h5010, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 1'b1, 16'h0050, 16'hD010, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 1'b0, 16'h8000, 16'hD010, 1'b0, 1'b0};
    tbl[20] = '{1'b1, 1'b1, 16'h8000, 16'h5010, 1'b0, 1'b0};

    RST = 1'b1;
    idle(2);
    RST = 1'b0;
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_status", {16'd0, rd_data}, 32'h2000);
    check("reset_irq", {31'd0, irq_empty}, 32'd1);

    exp_q.push_back(8'h55);
    bus_op(1'b1, 1'b1, 16'h0055);
    check("single_pre_tx", {31'd0, tx}, 32'd1);
    check("single_status", {16'd0, rd_data}, 32'h0001);
    fr = {1'b1, 8'h55, 1'b0};
    for (int k = 1; k <= 40; k++) begin
      idle(1);
      check($sformatf("single_tx_c%0d", k), {31'd0, tx}, {31'd0, fr[0]});
      check($sformatf("single_busy_c%0d", k), {31'd0, rd_data[12]}, 32'd1);
      if ((k % CPB) == 0) fr = fr >> 1;
    end
    idle(1);
    check("single_end_irq", {31'd0, irq_empty}, 32'd1);
    check("single_end_status", {16'd0, rd_data}, 32'h2000);

    idle(3);
    start_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'hFF);
    bus_op(1'b1, 1'b1, 16'h00A5);
    bus_op(1'b1, 1'b1, 16'h00FF);
    wait_drain(300);
    check("b2b_frames", start_q.size(), 32'd2);
    if (start_q.size() >= 2) check("b2b_gap", start_q[1] - start_q[0], 32'd40);

    e1 = 0;
    for (int i = 0; i < 21; i++) begin
      if (tbl[i].acc) exp_q.push_back(tbl[i].d[7:0]);
      bus_op(tbl[i].s, tbl[i].w, tbl[i].d);
      if (i == 1) e1 = cyc;
      check($sformatf("vec%0d_status", i), {16'd0, rd_data}, {16'd0, tbl[i].exp_rd});
      check($sformatf("vec%0d_irq", i), {31'd0, irq_empty}, {31'd0, tbl[i].exp_irq});
    end

    // Land a write on the edge where the first frame's last stop cycle pops the next byte.
    while (cyc < e1 + 39) idle(1);
    check("full_before_pop", {16'd0, rd_data}, 32'h5010);
    exp_q.push_back(8'hEE);
    bus_op(1'b1, 1'b1, 16'h00EE);
    check("full_push_pop_status", {16'd0, rd_data}, 32'h5010);
    idle(1);
    check("full_push_pop_hold", {16'd0, rd_data}, 32'h5010);
    wait_drain(1500);
    check("drain_status", {16'd0, rd_data}, 32'h2000);
    check("drain_irq", {31'd0, irq_empty}, 32'd1);

    bus_op(1'b1, 1'b1, 16'h00C3);
    n0 = cyc;
    bus_op(1'b1, 1'b1, 16'h003C);
    while (cyc < n0 + 17) idle(1);
    check("mid_busy", {31'd0, rd_data[12]}, 32'd1);
    check("mid_count", {27'd0, rd_data[4:0]}, 32'd1);
    RST = 1'b1;
    idle(1);
    RST = 1'b0;
    check("abort_tx", {31'd0, tx}, 32'd1);
    check("abort_status", {16'd0, rd_data}, 32'h2000);
    check("abort_irq", {31'd0, irq_empty}, 32'd1);
    idle(1);
    check("abort_tx_hold", {31'd0, tx}, 32'd1);

    start_q.delete();
    exp_q.push_back(8'h01);
    bus_op(1'b1, 1'b1, 16'h0001);
    wait_drain(300);
    check("post_abort_frames", start_q.size(), 32'd1);
    check("final_status", {16'd0, rd_data}, 32'h2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
